// File: rtl/alu_pkg.sv
// Shared alu definitions: opcode encoding, issue/execute FSM states and
// instruction field positions for the 16-bit instruction word.
package alu_pkg;

  typedef enum logic [2:0] {
    ADD      = 3'd0,
    SUBTRACT = 3'd1,
    AND_OP   = 3'd2,
    OR_OP    = 3'd3,
    XOR_OP   = 3'd4,
    NOT_OP   = 3'd5,
    REG      = 3'd6
  } instruction_code;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    WB
  } exec_state_t;

  // Instruction layout: [15:13] op, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm
  localparam int OP_MSB        = 15;
  localparam int RD_LSB        = 11;
  localparam int RS_LSB        = 9;
  localparam int IMM_SEL_BIT   = 8;
  localparam int USE_CARRY_BIT = 0;

endpackage

// File: rtl/alu.sv
// Combinational 8-bit alu; unencoded opcodes return zero with no carry.
module alu
  import alu_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [2:0]    opcode,
  input  logic [DW-1:0] i_1,
  input  logic [DW-1:0] i_2,
  input  logic          carry_in,
  output logic [DW-1:0] o_main,
  output logic          carry_out
);

  logic [DW:0] sum;

  always_comb begin
    sum       = {1'b0, i_1} + {1'b0, i_2} + {{DW{1'b0}}, carry_in};
    o_main    = '0;
    carry_out = 1'b0;
    case (opcode)
      ADD: begin
        o_main    = sum[DW-1:0];
        carry_out = sum[DW];
      end
      SUBTRACT: o_main = i_1 - i_2;
      AND_OP:   o_main = i_1 & i_2;
      OR_OP:    o_main = i_1 | i_2;
      XOR_OP:   o_main = i_1 ^ i_2;
      NOT_OP:   o_main = ~i_1;
      REG:      o_main = i_2;
      default:  o_main = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec_ctrl_regfile.sv
// NREG x DW register file: synchronous write and reset, two combinational
// operand read ports plus a combinational debug read port.
module alu_exec_ctrl_regfile #(
  parameter  int NREG = 4,
  parameter  int DW   = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  logic [DW-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a  = mem[raddr_a];
  assign rdata_b  = mem[raddr_b];
  assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/alu_exec_ctrl.sv
// Issue/execute controller for the alu: accepts one instruction per three
// cycles (IDLE -> EXEC -> WB), drives the alu and commits its result.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter  int NREG = 4,
  parameter  int DW   = 8,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic          alu_cin,
  input  logic [DW-1:0] alu_result,
  input  logic          alu_cout,
  output logic          wb_valid,
  output logic [AW-1:0] wb_rd,
  output logic [DW-1:0] wb_data,
  output logic          carry_flag,
  output logic          zero_flag,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  exec_state_t   state, state_nx;
  logic [15:0]   instr_q;
  logic [DW-1:0] res_q;
  logic          cout_q;
  logic          rf_we;
  logic [DW-1:0] rf_a, rf_b;

  logic [2:0]    op;
  logic [AW-1:0] rd, rs;
  logic          imm_sel, use_carry;
  logic [DW-1:0] imm;

  assign op        = instr_q[OP_MSB -: 3];
  assign rd        = instr_q[RD_LSB +: AW];
  assign rs        = instr_q[RS_LSB +: AW];
  assign imm_sel   = instr_q[IMM_SEL_BIT];
  assign imm       = instr_q[DW-1:0];
  assign use_carry = instr_q[USE_CARRY_BIT];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    rf_we       = 1'b0;
    unique case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = EXEC;
      end
      EXEC: state_nx = WB;
      WB: begin
        rf_we    = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // wb_* are loaded at the EXEC edge from the same value as res_q so the
  // pulse lines up with the WB cycle rather than trailing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      res_q      <= '0;
      cout_q     <= 1'b0;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      if (instr_ready && instr_valid) instr_q <= instr;
      if (state == EXEC) begin
        res_q    <= alu_result;
        cout_q   <= alu_cout;
        wb_valid <= 1'b1;
        wb_rd    <= rd;
        wb_data  <= alu_result;
      end
      if (state == WB) begin
        zero_flag <= (res_q == '0);
        if (op == ADD) carry_flag <= cout_q;
      end
    end
  end

  alu_exec_ctrl_regfile #(
    .NREG (NREG),
    .DW   (DW)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .we       (rf_we),
    .waddr    (rd),
    .wdata    (res_q),
    .raddr_a  (rd),
    .rdata_a  (rf_a),
    .raddr_b  (rs),
    .rdata_b  (rf_b),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  assign alu_op  = op;
  assign alu_a   = rf_a;
  assign alu_b   = imm_sel ? imm : rf_b;
  assign alu_cin = (op == ADD) & ~imm_sel & use_carry & carry_flag;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Self-checking bench for alu_exec_ctrl driving the real alu; expectations
// come from directed constants and an architectural register/flag model.
module tb_alu_exec_ctrl;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a, alu_b, alu_result, wb_data, dbg_data;
  logic        alu_cin, alu_cout, wb_valid, carry_flag, zero_flag;
  logic [1:0]  wb_rd;
  logic [1:0]  dbg_addr = '0;

  always #5 clk = ~clk;

  alu_exec_ctrl #(.NREG(4), .DW(8)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_result(alu_result), .alu_cout(alu_cout), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  alu #(.DW(8)) u_alu (
    .opcode(alu_op), .i_1(alu_a), .i_2(alu_b), .carry_in(alu_cin),
    .o_main(alu_result), .carry_out(alu_cout)
  );

  int n_cmp = 0;
  int n_err = 0;

  // architectural model
  logic [7:0] m_r [4];
  logic       m_c, m_z;

  // observations collected by run_instr
  logic       ob_rdy_before, ob_rdy_exec, ob_wb_exec, ob_wb, ob_wb_after, ob_rdy_after;
  logic [2:0] ob_op;
  logic [7:0] ob_a, ob_b, ob_wbdata, ob_dbg;
  logic       ob_cin, ob_c, ob_z;
  logic [1:0] ob_wbrd;

  typedef struct {
    logic [15:0] ins;
    logic [7:0]  d;
    logic        c, z, cin;
  } dir_t;

  function automatic logic [15:0] mk(input logic [2:0] op, input logic [1:0] rd,
                                     input logic [1:0] rs, input logic isel,
                                     input logic [7:0] imm);
    return {op, rd, rs, isel, imm};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = '0;
    m_c = 1'b0;
    m_z = 1'b0;
  endtask

  task automatic model_exec(input logic [15:0] ins, output logic [7:0] e_a,
                            output logic [7:0] e_b, output logic [7:0] e_res,
                            output logic e_cin);
    logic [2:0] op;
    logic [1:0] rd, rs;
    logic [8:0] s;
    op    = ins[15:13];
    rd    = ins[12:11];
    rs    = ins[10:9];
    e_a   = m_r[rd];
    e_b   = ins[8] ? ins[7:0] : m_r[rs];
    e_cin = (op == ADD) && !ins[8] && ins[0] && m_c;
    s     = 9'(e_a) + 9'(e_b) + 9'(e_cin);
    case (op)
      ADD:      e_res = s[7:0];
      SUBTRACT: e_res = e_a - e_b;
      AND_OP:   e_res = e_a & e_b;
      OR_OP:    e_res = e_a | e_b;
      XOR_OP:   e_res = e_a ^ e_b;
      NOT_OP:   e_res = ~e_a;
      REG:      e_res = e_b;
      default:  e_res = 8'h00;
    endcase
    m_r[rd] = e_res;
    m_z     = (e_res == 8'h00);
    if (op == ADD) m_c = s[8];
  endtask

  // Starts and ends on a falling edge; samples EXEC, WB and the cycle after.
  task automatic run_instr(input logic [15:0] ins);
    instr         = ins;
    instr_valid   = 1'b1;
    dbg_addr      = ins[12:11];
    ob_rdy_before = instr_ready;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    instr       = 16'($urandom);
    @(negedge clk);
    ob_rdy_exec = instr_ready;
    ob_wb_exec  = wb_valid;
    ob_op       = alu_op;
    ob_a        = alu_a;
    ob_b        = alu_b;
    ob_cin      = alu_cin;
    @(negedge clk);
    ob_wb     = wb_valid;
    ob_wbrd   = wb_rd;
    ob_wbdata = wb_data;
    @(negedge clk);
    ob_wb_after  = wb_valid;
    ob_rdy_after = instr_ready;
    ob_dbg       = dbg_data;
    ob_c         = carry_flag;
    ob_z         = zero_flag;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    model_reset();
    n_cmp++;
    if ({instr_ready, wb_valid, carry_flag, zero_flag} !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_ctrl: got rdy/wb/c/z=%b required 1000",
               {instr_ready, wb_valid, carry_flag, zero_flag});
    end
    n_cmp++;
    if ({wb_rd, wb_data, alu_op, alu_a, alu_b, alu_cin} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got wb_rd=%h wb_data=%h op=%h a=%h b=%h cin=%b required all 0",
               wb_rd, wb_data, alu_op, alu_a, alu_b, alu_cin);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_cmp++;
      if (dbg_data !== 8'h00) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h required 00", i, dbg_data);
      end
    end
  endtask

  task automatic test_directed();
    dir_t tbl [13];
    logic [7:0] ea, eb, er;
    logic ec;
    tbl[0]  = '{mk(REG,    2'd0, 2'd0, 1'b1, 8'h05), 8'h05, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{mk(REG,    2'd1, 2'd0, 1'b1, 8'h03), 8'h03, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{mk(ADD,    2'd0, 2'd1, 1'b0, 8'h00), 8'h08, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{mk(REG,    2'd0, 2'd0, 1'b1, 8'hFF), 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{mk(ADD,    2'd0, 2'd0, 1'b1, 8'h01), 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{mk(REG,    2'd0, 2'd0, 1'b1, 8'h10), 8'h10, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{mk(REG,    2'd1, 2'd0, 1'b1, 8'h20), 8'h20, 1'b1, 1'b0, 1'b0};
    tbl[7]  = '{mk(ADD,    2'd0, 2'd1, 1'b0, 8'h01), 8'h31, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{mk(REG,    2'd3, 2'd0, 1'b1, 8'hFF), 8'hFF, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{mk(ADD,    2'd3, 2'd0, 1'b1, 8'h01), 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[10] = '{mk(REG,    2'd2, 2'd0, 1'b1, 8'hAA), 8'hAA, 1'b1, 1'b0, 1'b0};
    tbl[11] = '{mk(XOR_OP, 2'd2, 2'd0, 1'b1, 8'hAA), 8'h00, 1'b1, 1'b1, 1'b0};
    tbl[12] = '{mk(NOT_OP, 2'd2, 2'd0, 1'b0, 8'h00), 8'hFF, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 13; i++) begin
      model_exec(tbl[i].ins, ea, eb, er, ec);
      run_instr(tbl[i].ins);
      n_cmp++;
      if ({ob_rdy_before, ob_rdy_exec, ob_wb_exec, ob_wb, ob_wb_after, ob_rdy_after} !== 6'b100101) begin
        n_err++;
        $display("FAIL dir%0d_timing: got rdy0/rdyE/wbE/wbW/wbA/rdyA=%b required 100101", i,
                 {ob_rdy_before, ob_rdy_exec, ob_wb_exec, ob_wb, ob_wb_after, ob_rdy_after});
      end
      n_cmp++;
      if (ob_cin !== tbl[i].cin) begin
        n_err++;
        $display("FAIL dir%0d_cin: got %b required %b", i, ob_cin, tbl[i].cin);
      end
      n_cmp++;
      if ({ob_wbrd, ob_wbdata, ob_dbg} !== {tbl[i].ins[12:11], tbl[i].d, tbl[i].d}) begin
        n_err++;
        $display("FAIL dir%0d_wb: got rd=%h data=%h reg=%h required rd=%h data=%h", i,
                 ob_wbrd, ob_wbdata, ob_dbg, tbl[i].ins[12:11], tbl[i].d);
      end
      n_cmp++;
      if ({ob_c, ob_z} !== {tbl[i].c, tbl[i].z}) begin
        n_err++;
        $display("FAIL dir%0d_flags: got c=%b z=%b required c=%b z=%b", i,
                 ob_c, ob_z, tbl[i].c, tbl[i].z);
      end
    end
  endtask

  task automatic test_unencoded();
    logic [7:0] ea, eb, er;
    logic ec, c_before;
    model_exec(mk(REG, 2'd2, 2'd0, 1'b1, 8'h5A), ea, eb, er, ec);
    run_instr(mk(REG, 2'd2, 2'd0, 1'b1, 8'h5A));
    c_before = m_c;
    model_exec(mk(3'd7, 2'd2, 2'd1, 1'b0, 8'h33), ea, eb, er, ec);
    run_instr(mk(3'd7, 2'd2, 2'd1, 1'b0, 8'h33));
    n_cmp++;
    if ({ob_wb, ob_wbdata, ob_dbg, ob_z, ob_c} !== {1'b1, 8'h00, 8'h00, 1'b1, c_before}) begin
      n_err++;
      $display("FAIL unencoded: got wb=%b data=%h reg=%h z=%b c=%b required 1 00 00 1 %b",
               ob_wb, ob_wbdata, ob_dbg, ob_z, ob_c, c_before);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] i1, i2;
    logic [7:0]  ea, eb, r1, r2;
    logic        ec;
    int          hs [$];
    logic [7:0]  wbs [$];
    i1 = mk(ADD, 2'd1, 2'd0, 1'b1, 8'h11);
    i2 = mk(ADD, 2'd0, 2'd1, 1'b0, 8'h00);
    model_exec(i1, ea, eb, r1, ec);
    model_exec(i2, ea, eb, r2, ec);
    instr       = i1;
    instr_valid = 1'b1;
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (wb_valid) wbs.push_back(wb_data);
      if (instr_ready && instr_valid) hs.push_back(cyc);
      @(posedge clk);
      #1;
      if (hs.size() == 1) instr = i2;
      if (hs.size() == 2) instr_valid = 1'b0;
      @(negedge clk);
    end
    n_cmp++;
    if (hs.size() != 2) begin
      n_err++;
      $display("FAIL b2b_accepts: got %0d handshakes required 2", hs.size());
    end else begin
      n_cmp++;
      if (hs[1] - hs[0] != 3) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d cycles required 3", hs[1] - hs[0]);
      end
    end
    n_cmp++;
    if (wbs.size() != 2) begin
      n_err++;
      $display("FAIL b2b_wb_count: got %0d required 2", wbs.size());
    end else begin
      n_cmp++;
      if ({wbs[0], wbs[1]} !== {r1, r2}) begin
        n_err++;
        $display("FAIL b2b_wb_data: got %h,%h required %h,%h", wbs[0], wbs[1], r1, r2);
      end
    end
    dbg_addr = 2'd0;
    #1;
    n_cmp++;
    if (dbg_data !== r2) begin
      n_err++;
      $display("FAIL b2b_raw: got R0=%h required %h", dbg_data, r2);
    end
  endtask

  task automatic test_random();
    logic [15:0] ins;
    logic [7:0]  ea, eb, er;
    logic        ec;
    for (int i = 0; i < 40; i++) begin
      ins = 16'($urandom);
      model_exec(ins, ea, eb, er, ec);
      run_instr(ins);
      n_cmp++;
      if ({ob_op, ob_a, ob_b, ob_cin} !== {ins[15:13], ea, eb, ec}) begin
        n_err++;
        $display("FAIL rnd%0d_alu_in: got op=%h a=%h b=%h cin=%b required op=%h a=%h b=%h cin=%b",
                 i, ob_op, ob_a, ob_b, ob_cin, ins[15:13], ea, eb, ec);
      end
      n_cmp++;
      if ({ob_wb_exec, ob_wb, ob_wb_after, ob_wbrd, ob_wbdata} !== {3'b010, ins[12:11], er}) begin
        n_err++;
        $display("FAIL rnd%0d_wb: got pulse=%b rd=%h data=%h required 010 rd=%h data=%h",
                 i, {ob_wb_exec, ob_wb, ob_wb_after}, ob_wbrd, ob_wbdata, ins[12:11], er);
      end
      n_cmp++;
      if ({ob_dbg, ob_c, ob_z, ob_rdy_after} !== {er, m_c, m_z, 1'b1}) begin
        n_err++;
        $display("FAIL rnd%0d_state: got reg=%h c=%b z=%b rdy=%b required %h %b %b 1",
                 i, ob_dbg, ob_c, ob_z, ob_rdy_after, er, m_c, m_z);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    logic wb_seen;
    logic [7:0] ea, eb, er;
    logic ec;
    model_exec(mk(REG, 2'd1, 2'd0, 1'b1, 8'h7E), ea, eb, er, ec);
    run_instr(mk(REG, 2'd1, 2'd0, 1'b1, 8'h7E));
    instr       = mk(ADD, 2'd0, 2'd1, 1'b1, 8'hC3);
    instr_valid = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    rst         = 1'b1;
    wb_seen     = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    @(negedge clk);
    n_cmp++;
    if (instr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_ready: got %b required 1", instr_ready);
    end
    for (int c = 0; c < 4; c++) begin
      if (wb_valid !== 1'b0) wb_seen = 1'b1;
      @(negedge clk);
    end
    n_cmp++;
    if ({wb_seen, carry_flag, zero_flag} !== 3'b000) begin
      n_err++;
      $display("FAIL rstmid_wb_flags: got wb_seen=%b c=%b z=%b required 000",
               wb_seen, carry_flag, zero_flag);
    end
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      n_cmp++;
      if (dbg_data !== m_r[i]) begin
        n_err++;
        $display("FAIL rstmid_reg%0d: got %h required %h", i, dbg_data, m_r[i]);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_reset();
    test_reset();
    test_directed();
    test_unencoded();
    test_back_to_back();
    test_random();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Upstream issue/execute controller that feeds the team's 8-bit alu.
- Accepts one 16-bit instruction per valid/ready handshake and reads operands from a local 4x8 register file or an immediate.
- Drives the alu opcode, operand and carry-in inputs, then registers the alu result.
- Writes the result back to the register file and maintains carry and zero flags.

Parameters:
- NREG, 4, number of 8-bit registers (rd/rs field width = $clog2(NREG) = 2).
- DW, 8, data width; must match the alu.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  an instruction is offered on instr.
- instr_ready  output  1  block can accept an instruction this cycle.
- instr  input  16  [15:13] op, [12:11] rd, [10:9] rs, [8] imm_sel, [7:0] imm (when imm_sel=0, bit[0] = use_carry).
- alu_op  output  3  opcode to the alu (alu_pkg::instruction_code encoding).
- alu_a  output  DW  operand i_1 = R[rd].
- alu_b  output  DW  operand i_2 = imm_sel ? imm : R[rs].
- alu_cin  output  1  carry-in = (op==ADD) & ~imm_sel & use_carry & carry_flag.
- alu_result  input  DW  alu o_main.
- alu_cout  input  1  alu carry_out; sampled only for ADD.
- wb_valid  output  1  one-cycle pulse when a write-back commits.
- wb_rd  output  2  destination register of the write-back.
- wb_data  output  DW  written value.
- carry_flag  output  1  sticky carry.
- zero_flag  output  1  last committed result == 0.
- dbg_addr  input  2  register-file debug read address.
- dbg_data  output  DW  R[dbg_addr], combinational.

Behaviour:
- Reset values: all registers R[0..3] = 0, state = IDLE, wb_valid = 0, wb_rd = 0, wb_data = 0, carry_flag = 0, zero_flag = 0, latched instruction = 0. alu_* outputs are derived from the latched instruction, so they read 0 after reset.
- FSM states: IDLE, EXEC, WB.
  - IDLE: instr_ready = 1. If instr_valid is high, latch instr and go to EXEC; otherwise stay in IDLE.
  - EXEC: instr_ready = 0. alu_* outputs are driven from the latched instruction and the current register file. Capture alu_result into res_q and alu_cout into cout_q. Go to WB.
  - WB: instr_ready = 0. Write R[rd] = res_q. Assert wb_valid with wb_rd = rd and wb_data = res_q. Set zero_flag = (res_q == 0). Set carry_flag = cout_q only if op == ADD; otherwise carry_flag holds. Go to IDLE.
- Latency and throughput:
  - Handshake at cycle N; wb_valid at cycle N+2.
  - Register value visible on dbg_data from cycle N+3.
  - instr_ready high again at N+3; throughput is 1 instruction per 3 cycles.
- alu_* outputs are stable from EXEC through WB. Outside EXEC they are don't-care for the bench but must still be deterministic (no X).
- Operand read-after-write: the next instruction's EXEC follows the previous WB's commit, so it always sees the updated register. No forwarding is needed.
- Operation rules:
  - SUBTRACT, AND_OP, OR_OP, XOR_OP, NOT_OP, REG: carry_flag unchanged.
  - NOT_OP ignores alu_b.
  - REG copies alu_b into rd (move/load-immediate).
  - Unencoded opcodes: the alu returns 0; the block commits 0 and sets zero_flag. No error is raised.
- instr_valid while not ready: ignored. The upstream holds instr stable until the handshake.
- rst mid-operation (in EXEC or WB): rst wins. Next state is IDLE, no write-back, wb_valid = 0, and the register file and flags reset to 0.
- Width rules: DW-bit wrap-around; ADD carry-out goes only to carry_flag.

Decomposition:
- alu_pkg (existing) supplies instruction_code.
- Add to alu_pkg:
  - exec_state_t enum {IDLE, EXEC, WB};
  - instruction field localparams (OP_MSB=15, RD_LSB=11, RS_LSB=9, IMM_SEL_BIT=8, USE_CARRY_BIT=0).
- Sub-module regfile: NREG x DW, synchronous write, two combinational read ports plus the debug port, synchronous reset to 0.
- The bench instantiates alu_exec_ctrl together with the real alu.

Test Plan:
- Reset, then load immediates with REG: rd=0 imm=0x05, rd=1 imm=0x03 -> wb_valid at N+2 each time, R0=0x05, R1=0x03, zero_flag=0.
- ADD rd=0 rs=1 (R0=0x05, R1=0x03) -> R0=0x08, carry_flag=0. Then R0=0xFF, imm 0x01 ADD -> R0=0x00, carry_flag=1, zero_flag=1.
- ADD with use_carry=1, carry_flag=1, R0=0x10, R1=0x20 -> alu_cin=1 in EXEC, R0=0x31, carry_flag=0.
- With carry_flag=1: XOR_OP R2=0xAA with imm 0xAA -> R2=0x00, zero_flag=1, carry_flag stays 1. Then NOT_OP R2 -> 0xFF.
- Back-to-back instructions with instr_valid held high -> instr_ready pulses every 3 cycles; each instruction is accepted exactly once; the second sees the first's result.
- Assert rst during EXEC of an ADD -> no wb_valid; all registers 0, flags 0, instr_ready=1 the cycle after reset deasserts.
